// File: rtl/mult_sequencer_if.sv
// Execute-stage multiply bus: issue side drives operands/control,
// sequencer side returns stall, done pulse, result words and N/Z flags.
interface mult_sequencer_if;
    logic        StartE;
    logic        FlushE;
    logic [2:0]  MulTypeE;
    logic [31:0] RmE;
    logic [31:0] RsE;
    logic [31:0] AccLoE;
    logic [31:0] AccHiE;
    logic        StallE;
    logic        MulDoneE;
    logic [31:0] ResultLo;
    logic [31:0] ResultHi;
    logic        MulN;
    logic        MulZ;

    modport master (
        output StartE, FlushE, MulTypeE, RmE, RsE, AccLoE, AccHiE,
        input  StallE, MulDoneE, ResultLo, ResultHi, MulN, MulZ
    );

    modport slave (
        input  StartE, FlushE, MulTypeE, RmE, RsE, AccLoE, AccHiE,
        output StallE, MulDoneE, ResultLo, ResultHi, MulN, MulZ
    );
endinterface

// File: rtl/mult_sequencer.sv
// Iterative shift-add multiplier for MUL/MLA/UMULL/UMLAL/SMULL/SMLAL.
// Ports: clk, reset (sync, active-high), bus (mult_sequencer_if.slave):
//   in : StartE FlushE MulTypeE[2:0] RmE RsE AccLoE AccHiE
//   out: StallE MulDoneE ResultLo ResultHi MulN MulZ
// MULT_EARLY_TERM_EN: leave ITER once the remaining multiplier is zero.
module mult_sequencer #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    mult_sequencer_if.slave  bus
);
    localparam int NITER = 32 / BITS_PER_CYCLE;
    localparam int CW    = 6;

    typedef enum logic [2:0] {
        IDLE, SETUP, ITER, SIGN, ACCUM, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [2:0]  type_q, type_d;
    logic        neg_q, neg_d;
    logic [63:0] prod_q, prod_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic        n_q, n_d;
    logic        z_q, z_d;
    logic        done_q, done_d;

    logic [63:0] step;
    logic [31:0] mplier_nxt;
    logic        iter_exit;
    logic        sgn_long;
    logic [63:0] acc_add;
    logic [63:0] sum;

    // Partial product for the low BITS_PER_CYCLE multiplier bits.
    always_comb begin
        step = '0;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            if (mplier_q[b]) step = step + (mcand_q << b);
        end
    end

    assign mplier_nxt = mplier_q >> BITS_PER_CYCLE;
    assign sgn_long   = type_q[2] & type_q[1];
    assign acc_add    = type_q[0] ?
                        {type_q[2] ? acc_hi_q : 32'd0, acc_lo_q} : 64'd0;
    assign sum        = prod_q + acc_add;

`ifdef MULT_EARLY_TERM_EN
    assign iter_exit = (cnt_q == CW'(NITER - 1)) || (mplier_nxt == 32'd0);
`else
    assign iter_exit = (cnt_q == CW'(NITER - 1));
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_lo_d = acc_lo_q;
        acc_hi_d = acc_hi_q;
        type_d   = type_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        n_d      = n_q;
        z_d      = z_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.StartE && !bus.FlushE) begin
                    mcand_d  = {32'd0, bus.RmE};
                    mplier_d = bus.RsE;
                    acc_lo_d = bus.AccLoE;
                    acc_hi_d = bus.AccHiE;
                    type_d   = bus.MulTypeE;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                // Signed long works on magnitudes; sign restored in SIGN.
                if (sgn_long && mcand_q[31])
                    mcand_d = {32'd0, 32'd0 - mcand_q[31:0]};
                if (sgn_long && mplier_q[31])
                    mplier_d = 32'd0 - mplier_q;
                neg_d   = sgn_long & (mcand_q[31] ^ mplier_q[31]);
                prod_d  = '0;
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                prod_d   = prod_q + step;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_nxt;
                cnt_d    = cnt_q + CW'(1);
                if (iter_exit) state_d = SIGN;
            end
            SIGN: begin
                if (neg_q) prod_d = 64'd0 - prod_q;
                state_d = ACCUM;
            end
            ACCUM: begin
                res_lo_d = sum[31:0];
                res_hi_d = type_q[2] ? sum[63:32] : 32'd0;
                n_d      = type_q[2] ? sum[63] : sum[31];
                z_d      = type_q[2] ? (sum == 64'd0) :
                                       (sum[31:0] == 32'd0);
                done_d   = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort: results from an aborted op must never become visible.
        if (bus.FlushE) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            res_lo_d = res_lo_q;
            res_hi_d = res_hi_q;
            n_d      = n_q;
            z_d      = z_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_lo_q <= '0;
            acc_hi_q <= '0;
            type_q   <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            cnt_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_lo_q <= acc_lo_d;
            acc_hi_q <= acc_hi_d;
            type_q   <= type_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            n_q      <= n_d;
            z_q      <= z_d;
            done_q   <= done_d;
        end
    end

    // Stall must react in the accept cycle, so it is decoded from state.
    assign bus.StallE = ((state_q == IDLE) & bus.StartE & ~bus.FlushE) |
                        (((state_q == SETUP) | (state_q == ITER) |
                          (state_q == SIGN)  | (state_q == ACCUM)) &
                         ~bus.FlushE);
    assign bus.MulDoneE = done_q;
    assign bus.ResultLo = res_lo_q;
    assign bus.ResultHi = res_hi_q;
    assign bus.MulN     = n_q;
    assign bus.MulZ     = z_q;
endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: arithmetic table, latency/stall,
// operand hold, flush, reset abort and early-termination latency.
module tb_mult_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mult_sequencer_if bus();

    mult_sequencer #(.BITS_PER_CYCLE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  t;
        logic [31:0] rm;
        logic [31:0] rs;
        logic [31:0] alo;
        logic [31:0] ahi;
        logic [63:0] res;
        logic        n;
        logic        z;
    } vec_t;

    // Expected latency: 32 iterations, or under early termination the
    // index of the highest set bit of the multiplier magnitude (min 1).
    function automatic int exp_lat(input logic [2:0] t,
                                   input logic [31:0] rs);
        logic [31:0] m;
        int          n;
        m = (t[2] & t[1] & rs[31]) ? 32'd0 - rs : rs;
        n = 1;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
`ifndef MULT_EARLY_TERM_EN
        n = 32;
`endif
        return n + 4;
    endfunction

    // Called at a point inside cycle 0; returns inside cycle lat+1.
    task automatic run_op(input logic [2:0] t, input logic [31:0] rm,
                          input logic [31:0] rs, input logic [31:0] alo,
                          input logic [31:0] ahi, input bit keep,
                          input int flush_c, output int done_c,
                          output int stall_bad, output int extra);
        int lat;
        lat = exp_lat(t, rs);
        bus.MulTypeE = t;
        bus.RmE      = rm;
        bus.RsE      = rs;
        bus.AccLoE   = alo;
        bus.AccHiE   = ahi;
        bus.StartE   = 1'b1;
        bus.FlushE   = (flush_c == 0);
        done_c    = -1;
        stall_bad = 0;
        extra     = 0;
        for (int c = 0; c < 80; c++) begin
            #2;
            if (bus.FlushE) begin
                if (bus.StallE !== 1'b0) stall_bad++;
            end else if (bus.StallE !== (c < lat)) stall_bad++;
            if (bus.MulDoneE === 1'b1) begin
                done_c = c;
                break;
            end
            @(negedge clk);
            bus.FlushE = (flush_c == c + 1);
            if (!keep) bus.StartE = 1'b0;
            else begin
                bus.RmE    = $urandom;
                bus.RsE    = $urandom;
                bus.AccLoE = $urandom;
                bus.AccHiE = $urandom;
                bus.MulTypeE = 3'($urandom);
            end
        end
        @(negedge clk);
        bus.StartE = 1'b0;
        bus.FlushE = 1'b0;
        #1;
        if (bus.MulDoneE !== 1'b0) extra = 1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.StartE   = 1'b0;
        bus.FlushE   = 1'b0;
        bus.MulTypeE = '0;
        bus.RmE      = '0;
        bus.RsE      = '0;
        bus.AccLoE   = '0;
        bus.AccHiE   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.StallE, bus.MulDoneE, bus.MulN, bus.MulZ,
             bus.ResultHi, bus.ResultLo} !== 68'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {bus.StallE, bus.MulDoneE, bus.MulN, bus.MulZ,
                      bus.ResultHi, bus.ResultLo});
        end
    endtask

    task automatic test_arith();
        vec_t v[10];
        int   d, sb, ex, lat;
        v[0] = '{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
                 64'hFFFFFFFE_00000001, 1'b1, 1'b0};
        v[1] = '{3'b110, 32'hFFFFFFFE, 32'h3, 32'h0, 32'h0,
                 64'hFFFFFFFF_FFFFFFFA, 1'b1, 1'b0};
        v[2] = '{3'b110, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0, 32'h0,
                 64'h6, 1'b0, 1'b0};
        v[3] = '{3'b001, 32'h5, 32'h7, 32'h10, 32'hDEADBEEF,
                 64'h33, 1'b0, 1'b0};
        v[4] = '{3'b000, 32'h1234, 32'h0, 32'h55, 32'h66,
                 64'h0, 1'b0, 1'b1};
        v[5] = '{3'b101, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 64'h0, 1'b0, 1'b1};
        v[6] = '{3'b111, 32'hFFFFFFFE, 32'h3, 32'hA, 32'h0,
                 64'h4, 1'b0, 1'b0};
        v[7] = '{3'b010, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0,
                 64'h00000000_FFFFFFFE, 1'b1, 1'b0};
        v[8] = '{3'b110, 32'h7, 32'hFFFFFFFF, 32'h0, 32'h0,
                 64'hFFFFFFFF_FFFFFFF9, 1'b1, 1'b0};
        v[9] = '{3'b101, 32'h2, 32'h3, 32'hFFFFFFFF, 32'h1,
                 64'h2_00000005, 1'b0, 1'b0};
        // Consecutive run_op calls start in the IDLE cycle after DONE.
        foreach (v[i]) begin
            lat = exp_lat(v[i].t, v[i].rs);
            run_op(v[i].t, v[i].rm, v[i].rs, v[i].alo, v[i].ahi,
                   1'b0, -1, d, sb, ex);
            checks++;
            if (d !== lat) begin
                failures++;
                $display("FAIL arith%0d_latency got=%0d exp=%0d",
                         i, d, lat);
            end
            checks++;
            if (sb !== 0) begin
                failures++;
                $display("FAIL arith%0d_stall bad_cycles=%0d exp=0",
                         i, sb);
            end
            checks++;
            if (ex !== 0) begin
                failures++;
                $display("FAIL arith%0d_done_width got=%0d exp=0",
                         i, ex);
            end
            checks++;
            if ({bus.ResultHi, bus.ResultLo} !== v[i].res) begin
                failures++;
                $display("FAIL arith%0d_result got=%h exp=%h", i,
                         {bus.ResultHi, bus.ResultLo}, v[i].res);
            end
            checks++;
            if ({bus.MulN, bus.MulZ} !== {v[i].n, v[i].z}) begin
                failures++;
                $display("FAIL arith%0d_nz got=%b exp=%b", i,
                         {bus.MulN, bus.MulZ}, {v[i].n, v[i].z});
            end
        end
    endtask

    task automatic test_operand_hold();
        int d, sb, ex;
        // StartE stays high and operands churn after capture.
        run_op(3'b000, 32'd6, 32'd7, 32'd0, 32'd0, 1'b1, -1, d, sb, ex);
        checks++;
        if (d !== exp_lat(3'b000, 32'd7) || sb !== 0) begin
            failures++;
            $display("FAIL hold_timing got=%0d/%0d exp=%0d/0",
                     d, sb, exp_lat(3'b000, 32'd7));
        end
        checks++;
        if ({bus.ResultHi, bus.ResultLo} !== 64'd42) begin
            failures++;
            $display("FAIL hold_result got=%h exp=%h",
                     {bus.ResultHi, bus.ResultLo}, 64'd42);
        end
    endtask

    task automatic test_flush_done();
        int d, sb, ex, lat;
        lat = exp_lat(3'b100, 32'h10);
        // Flush raised in the DONE cycle: the pulse is still seen.
        run_op(3'b100, 32'h3, 32'h10, 32'h0, 32'h0, 1'b0, lat,
               d, sb, ex);
        checks++;
        if (d !== lat || ex !== 0) begin
            failures++;
            $display("FAIL flush_done_pulse got=%0d/%0d exp=%0d/0",
                     d, ex, lat);
        end
        checks++;
        if (bus.ResultLo !== 32'h30) begin
            failures++;
            $display("FAIL flush_done_result got=%h exp=%h",
                     bus.ResultLo, 32'h30);
        end
    endtask

    task automatic test_flush();
        int d, sb, ex, dn;
        bus.MulTypeE = 3'b100;
        bus.RmE      = 32'hFFFFFFFF;
        bus.RsE      = 32'hFFFFFFFF;
        bus.StartE   = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus.FlushE = (c == 10);
            #1;
            if (c == 5) begin
                checks++;
                if (bus.ResultLo !== 32'h30) begin
                    failures++;
                    $display("FAIL result_hold got=%h exp=%h",
                             bus.ResultLo, 32'h30);
                end
            end
            if (c >= 10) begin
                checks++;
                if (bus.StallE !== 1'b0 || bus.MulDoneE !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_c%0d stall/done got=%b%b exp=00",
                             c, bus.StallE, bus.MulDoneE);
                end
            end
            @(negedge clk);
            bus.StartE = 1'b0;
        end
        bus.FlushE = 1'b0;
        // Cycle 12: new op completes in cycle 48.
        run_op(3'b100, 32'h3, 32'h80000000, 32'h0, 32'h0, 1'b0, -1,
               d, sb, ex);
        checks++;
        if (d !== 36 || sb !== 0) begin
            failures++;
            $display("FAIL flush_restart_lat got=%0d/%0d exp=36/0",
                     d, sb);
        end
        checks++;
        if ({bus.ResultHi, bus.ResultLo} !== 64'h1_80000000) begin
            failures++;
            $display("FAIL flush_restart_res got=%h exp=%h",
                     {bus.ResultHi, bus.ResultLo}, 64'h1_80000000);
        end
        // StartE with FlushE in IDLE: nothing is captured.
        bus.StartE = 1'b1;
        bus.FlushE = 1'b1;
        @(negedge clk);
        bus.StartE = 1'b0;
        bus.FlushE = 1'b0;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.StallE !== 1'b0 || bus.MulDoneE !== 1'b0) dn++;
            @(negedge clk);
        end
        checks++;
        if (dn !== 0) begin
            failures++;
            $display("FAIL start_flush_idle activity=%0d exp=0", dn);
        end
    endtask

    task automatic test_reset_mid();
        int dn;
        bus.MulTypeE = 3'b100;
        bus.RmE      = 32'hFFFFFFFF;
        bus.RsE      = 32'hFFFFFFFF;
        bus.StartE   = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.StartE = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.StallE, bus.MulDoneE, bus.MulN, bus.MulZ,
             bus.ResultHi, bus.ResultLo} !== 68'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%h exp=0",
                     {bus.StallE, bus.MulDoneE, bus.MulN, bus.MulZ,
                      bus.ResultHi, bus.ResultLo});
        end
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (bus.MulDoneE !== 1'b0) dn++;
        end
        checks++;
        if (dn !== 0) begin
            failures++;
            $display("FAIL reset_mid_done pulses=%0d exp=0", dn);
        end
    endtask

    task automatic test_early_term();
        int d, sb, ex, l3, l0;
`ifdef MULT_EARLY_TERM_EN
        l3 = 6;
        l0 = 5;
`else
        l3 = 36;
        l0 = 36;
`endif
        run_op(3'b000, 32'd9, 32'd3, 32'd0, 32'd0, 1'b0, -1, d, sb, ex);
        checks++;
        if (d !== l3 || sb !== 0) begin
            failures++;
            $display("FAIL et_rs3_lat got=%0d/%0d exp=%0d/0", d, sb, l3);
        end
        checks++;
        if (bus.ResultLo !== 32'd27 || bus.MulZ !== 1'b0) begin
            failures++;
            $display("FAIL et_rs3_res got=%h/%b exp=%h/0",
                     bus.ResultLo, bus.MulZ, 32'd27);
        end
        run_op(3'b000, 32'd9, 32'd0, 32'd0, 32'd0, 1'b0, -1, d, sb, ex);
        checks++;
        if (d !== l0 || sb !== 0) begin
            failures++;
            $display("FAIL et_rs0_lat got=%0d/%0d exp=%0d/0", d, sb, l0);
        end
        checks++;
        if (bus.ResultLo !== 32'd0 || bus.MulZ !== 1'b1) begin
            failures++;
            $display("FAIL et_rs0_res got=%h/%b exp=0/1",
                     bus.ResultLo, bus.MulZ);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_operand_hold();
        test_flush_done();
        test_flush();
        test_reset_mid();
        test_early_term();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Multi-cycle multiply controller in the Execute stage for MUL, MLA, UMULL, UMLAL, SMULL and SMLAL.
- Captures operands when a multiply enters Execute and stalls the pipeline while the iterative shift-add proceeds.
- Then applies sign correction and accumulation, and presents a 32- or 64-bit result with N/Z flags for one cycle.
- Sits beside the ALU decoder; its results replace the ALU result on multiply instructions.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per ITER cycle; legal values 1, 2, 4, 8. ITER length is NITER = 32/BITS_PER_CYCLE.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- StartE  input  1  multiply instruction valid in Execute
- FlushE  input  1  synchronous abort of the current/pending operation
- MulTypeE  input  3  bit2 = long, bit1 = signed, bit0 = accumulate; 000 MUL, 001 MLA, 100 UMULL, 101 UMLAL, 110 SMULL, 111 SMLAL
- RmE  input  32  multiplicand
- RsE  input  32  multiplier
- AccLoE  input  32  accumulator low word (Rn, or RdLo for long)
- AccHiE  input  32  accumulator high word (RdHi); ignored for short types
- StallE  output  1  hold Execute and earlier stages
- MulDoneE  output  1  result valid, single-cycle pulse
- ResultLo  output  32  product low word
- ResultHi  output  32  product high word; 0 for short types
- MulN  output  1  N flag of result
- MulZ  output  1  Z flag of result

Behaviour:
- Reset: state IDLE; StallE, MulDoneE, MulN, MulZ = 0; ResultLo, ResultHi = 0; internal registers cleared. Reset mid-operation aborts with no MulDoneE.
- States: IDLE, SETUP, ITER, SIGN, ACCUM, DONE.
- IDLE: on StartE & ~FlushE, capture RmE, RsE, AccLoE, AccHiE, MulTypeE, then go to SETUP.
- Operand changes after capture are ignored.
- StartE is ignored in every state except IDLE.
- SETUP: for signed long types, replace each negative operand with its two's-complement magnitude and record the sign as the XOR of the two operand signs.
- Short types are always treated as unsigned; bit1 is ignored when bit2 = 0.
- SETUP clears the 64-bit product and the iteration counter, then goes to ITER.
- ITER: each cycle adds (multiplicand shifted left by iteration*BITS_PER_CYCLE) times the low BITS_PER_CYCLE bits of the remaining multiplier. The multiplier then shifts right by BITS_PER_CYCLE.
- ITER lasts exactly NITER cycles, then goes to SIGN.
- SIGN: if the sign flag is set, negate the 64-bit product; otherwise hold. Always 1 cycle.
- ACCUM: add {AccHi, AccLo} (long) or {32'b0, AccLo} (short) when bit0 = 1; otherwise add 0. Arithmetic is modulo 2^64 with carry out discarded. Always 1 cycle.
- DONE: MulDoneE = 1 for exactly this cycle. ResultLo/ResultHi, MulN and MulZ are valid; next state is IDLE.
- Results and flags hold their values until the next DONE.
- Short types: ResultHi = 0, MulN = bit 31 and MulZ = (low 32 bits == 0).
- Long types: MulN = bit 63 and MulZ = (64 bits == 0).
- C and V are never produced.
- Latency: StartE sampled in cycle 0 gives MulDoneE in cycle NITER+4 (cycle 36 for BITS_PER_CYCLE = 1).
- StallE = (IDLE & StartE & ~FlushE) | (state in SETUP..ACCUM & ~FlushE). StallE is low in DONE so the pipeline advances with the result.
- FlushE: in any state, the next state is IDLE and MulDoneE is not asserted in the next cycle. StallE is low in the flush cycle.
- StartE and FlushE together in IDLE: flush wins and no capture occurs.
- FlushE asserted in the DONE cycle: MulDoneE still pulses, since the result is already valid; the consumer squashes it.
- Back-to-back operations: StartE in the cycle after DONE is accepted from IDLE normally. There is at least one IDLE cycle between operations.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: ITER exits to SIGN when the iteration just executed is the last one, or when the remaining multiplier after that cycle's shift is zero. ITER takes a minimum of 1 cycle and latency becomes NITER_actual+4.
- Undefined: fixed NITER-cycle ITER and fixed latency.

Test Plan:
- UMULL RmE = 0xFFFFFFFF, RsE = 0xFFFFFFFF, BITS_PER_CYCLE = 1, StartE in cycle 0 -> StallE high in cycles 0..35, MulDoneE only in cycle 36. ResultHi = 0xFFFFFFFE, ResultLo = 0x00000001, MulN = 1, MulZ = 0.
- SMULL RmE = 0xFFFFFFFE (-2), RsE = 3 -> ResultHi = 0xFFFFFFFF, ResultLo = 0xFFFFFFFA, MulN = 1. SMULL with -2 * -3 -> result 0x0000000000000006, MulN = 0.
- MLA RmE = 5, RsE = 7, AccLoE = 0x10 -> ResultLo = 0x33, ResultHi = 0, MulZ = 0. MUL with RsE = 0 -> ResultLo = 0, MulZ = 1.
- UMLAL RmE = 1, RsE = 1, AccHiE = AccLoE = 0xFFFFFFFF -> result 0 (wrap), MulZ = 1, MulN = 0.
- Flush and reset:
  - FlushE in cycle 10 of UMULL -> no MulDoneE, StallE low in cycle 10 and stays low, state IDLE.
  - A new StartE in cycle 12 completes correctly in cycle 48.
  - Reset asserted in cycle 20 -> all outputs 0 in the following cycle, no MulDoneE.
- MULT_EARLY_TERM_EN, BITS_PER_CYCLE = 1, MUL RmE = 9, RsE = 3 -> MulDoneE in cycle 6, ResultLo = 27. With RsE = 0 -> MulDoneE in cycle 5, MulZ = 1. Macro undefined -> both cases complete in cycle 36.
